// File: rtl/bram_pkg.sv
// Shared constants and helpers for the dual-port block RAM primitives.
package bram_pkg;

  localparam logic [1:0] WM_READ_FIRST  = 2'd0;
  localparam logic [1:0] WM_WRITE_FIRST = 2'd1;
  localparam logic [1:0] WM_NO_CHANGE   = 2'd2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Widest word / lane count the merge helper can handle.
  localparam int MAX_DW = 512;
  localparam int MAX_NB = 64;

  function automatic int nbytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] be,
                                                   input int                bw);
    logic [MAX_DW-1:0] r;
    int idx;
    r = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      idx = i / bw;
      if (idx < MAX_NB && be[idx]) r[i] = new_w[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then reports READY.
module bram_clear_seq
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  logic [0:0]            state_d, state_q;
  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/bram_sync_dp.sv
// Single-clock true dual-port RAM with byte enables, read-during-write modes,
// optional output register and post-reset clear. Optional: BRAM_DP_COLLISION_EN.
module bram_sync_dp
  import bram_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 4,
  parameter int    BYTE_WIDTH     = 8,
  parameter string WRITE_MODE     = "READ_FIRST",
  parameter int    OUT_REG        = 0,
  parameter int    CLEAR_ON_RESET = 1,
  localparam int   NB             = nbytes(DATA_WIDTH, BYTE_WIDTH),
  localparam int   DEPTH          = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_wr,
  input  logic [NB-1:0]         a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_wr,
  input  logic [NB-1:0]         b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
`ifdef BRAM_DP_COLLISION_EN
  output logic                  collision,
`endif
  output logic                  init_busy
);

  localparam logic [1:0] WM = (WRITE_MODE == "WRITE_FIRST") ? WM_WRITE_FIRST :
                              (WRITE_MODE == "NO_CHANGE")   ? WM_NO_CHANGE   : WM_READ_FIRST;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy;
  logic [ADDR_WIDTH-1:0] clr_addr;

  bram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_addr(clr_addr)
  );
  assign init_busy = busy;

  // Index 0 = port A, 1 = port B.
  logic [1:0]                 acc, we;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] din, old_w, mrg_w, wr_w;
  logic [1:0][NB-1:0]         be;
  logic [1:0][DATA_WIDTH-1:0] dout1_d, dout1_q;
  logic [1:0]                 vld1_d, vld1_q;
  logic [MAX_DW-1:0]          tmp;

  // The clear sequencer borrows port A's write path while busy.
  always_comb begin
    acc  = '0;
    we   = '0;
    addr = {b_addr, a_addr};
    din  = {b_din, a_din};
    be   = {b_be, a_be};
    if (!rst && !busy) begin
      acc = {b_en, a_en};
      we  = {b_en & b_wr, a_en & a_wr};
    end else if (!rst) begin
      we[0]   = 1'b1;
      addr[0] = clr_addr;
      din[0]  = '0;
      be[0]   = '1;
    end
  end

  always_comb begin
    tmp = '0;
    for (int p = 0; p < 2; p++) begin
      old_w[p]   = mem_q[addr[p]];
      tmp        = byte_merge(MAX_DW'(old_w[p]), MAX_DW'(din[p]), MAX_NB'(be[p]), BYTE_WIDTH);
      mrg_w[p]   = tmp[DATA_WIDTH-1:0];
      vld1_d[p]  = acc[p] && !(we[p] && WM == WM_NO_CHANGE);
      dout1_d[p] = dout1_q[p];
      if (vld1_d[p])
        dout1_d[p] = (we[p] && WM == WM_WRITE_FIRST) ? mrg_w[p] : old_w[p];
    end
    // Same-address dual write: A's lanes layered over B's merged word.
    wr_w[1] = mrg_w[1];
    wr_w[0] = mrg_w[0];
    if (we[1] && addr[1] == addr[0]) begin
      tmp     = byte_merge(MAX_DW'(mrg_w[1]), MAX_DW'(din[0]), MAX_NB'(be[0]), BYTE_WIDTH);
      wr_w[0] = tmp[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (we[1]) mem_q[addr[1]] <= wr_w[1];
    if (we[0]) mem_q[addr[0]] <= wr_w[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout1_q <= '0;
      vld1_q  <= '0;
    end else begin
      dout1_q <= dout1_d;
      vld1_q  <= vld1_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [1:0][DATA_WIDTH-1:0] dout2_d, dout2_q;
    logic [1:0]                 vld2_q;

    always_comb begin
      for (int p = 0; p < 2; p++)
        dout2_d[p] = vld1_q[p] ? dout1_q[p] : dout2_q[p];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout2_q <= '0;
        vld2_q  <= '0;
      end else begin
        dout2_q <= dout2_d;
        vld2_q  <= vld1_q;
      end
    end

    assign a_dout  = dout2_q[0];
    assign b_dout  = dout2_q[1];
    assign a_valid = vld2_q[0];
    assign b_valid = vld2_q[1];
  end else begin : g_noreg
    assign a_dout  = dout1_q[0];
    assign b_dout  = dout1_q[1];
    assign a_valid = vld1_q[0];
    assign b_valid = vld1_q[1];
  end

`ifdef BRAM_DP_COLLISION_EN
  logic collision_d, collision_q;

  always_comb begin
    collision_d = acc[0] && acc[1] && (addr[0] == addr[1]) && (we[0] || we[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= collision_d;
  end

  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_bram_sync_dp.sv
// Directed bench: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST+OUT_REG) share stimulus.
module tb_bram_sync_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_en = 0, a_wr = 0, b_en = 0, b_wr = 0;
  logic [3:0]  a_be = 0, b_be = 0, a_addr = 0, b_addr = 0;
  logic [31:0] a_din = 0, b_din = 0;

  logic [31:0] a_dout_w [4];
  logic [31:0] b_dout_w [4];
  logic        a_valid_w [4];
  logic        b_valid_w [4];
  logic        busy_w [4];
`ifdef BRAM_DP_COLLISION_EN
  logic        coll_w [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bram_sync_dp #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
      .WRITE_MODE(g == 1 ? "WRITE_FIRST" : (g == 2 ? "NO_CHANGE" : "READ_FIRST")),
      .OUT_REG(g == 3 ? 1 : 0), .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout_w[g]), .a_valid(a_valid_w[g]),
      .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
      .b_dout(b_dout_w[g]), .b_valid(b_valid_w[g]),
`ifdef BRAM_DP_COLLISION_EN
      .collision(coll_w[g]),
`endif
      .init_busy(busy_w[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic wr, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] din);
    a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic count_clear(input string tag);
    int n;
    logic bad_v;
    n = 0;
    bad_v = 1'b0;
    while (busy_w[0] && n < 40) begin
      if (a_valid_w[0] || b_valid_w[0]) bad_v = 1'b1;
      n++;
      tick;
    end
    check(tag, n, 16);
    check({tag, "_valid"}, bad_v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick; tick;
    check("rst_dout", a_dout_w[0], 0);
    check("rst_valid", a_valid_w[0], 0);

    // Clear sequence; accesses attempted during it must be ignored.
    rst = 1'b0;
    set_a(1, 1, 4'hf, 4'd2, 32'hffff_ffff);
    b_en = 1'b1; b_wr = 1'b0; b_addr = 4'd0;
    count_clear("clr_len");
    set_a(0, 0, 0, 0, 0);
    b_en = 1'b0;

    for (int i = 0; i < 16; i++) begin
      set_a(1, 0, 0, 4'(i), 0);
      tick;
      check("clr_rd", a_dout_w[0], 0);
      check("clr_rd_v", a_valid_w[0], 1);
    end
    set_a(0, 0, 0, 0, 0);
    tick;
    check("idle_v", a_valid_w[0], 0);

    // Byte merge and write modes.
    set_a(1, 1, 4'hf, 4'd3, 32'hAABB_CCDD);
    tick;
    set_a(1, 1, 4'b0101, 4'd3, 32'h1122_3344);
    tick;
    check("rf_wr", a_dout_w[0], 32'hAABB_CCDD);
    check("rf_wr_v", a_valid_w[0], 1);
    check("wf_wr", a_dout_w[1], 32'hAA22_CC44);
    check("wf_wr_v", a_valid_w[1], 1);
    check("nc_wr", a_dout_w[2], 0);
    check("nc_wr_v", a_valid_w[2], 0);
    set_a(1, 0, 0, 4'd3, 0);
    tick;
    check("rf_rd3", a_dout_w[0], 32'hAA22_CC44);
    check("wf_rd3", a_dout_w[1], 32'hAA22_CC44);
    check("nc_rd3", a_dout_w[2], 32'hAA22_CC44);
    set_a(1, 1, 4'h0, 4'd3, 32'hFFFF_FFFF);
    tick;
    check("rf_be0", a_dout_w[0], 32'hAA22_CC44);
    check("wf_be0", a_dout_w[1], 32'hAA22_CC44);
    check("nc_be0_v", a_valid_w[2], 0);
    set_a(0, 0, 0, 0, 0);
    tick;
    check("hold_dout", a_dout_w[0], 32'hAA22_CC44);
    check("hold_v", a_valid_w[0], 0);
    set_a(1, 0, 0, 4'd3, 0);
    tick;
    check("be0_unch", a_dout_w[0], 32'hAA22_CC44);

    // Same-address dual write.
    set_a(1, 1, 4'b0011, 4'd7, 32'h1111_1111);
    b_en = 1; b_wr = 1; b_be = 4'hf; b_addr = 4'd7; b_din = 32'h2222_2222;
    tick;
`ifdef BRAM_DP_COLLISION_EN
    check("coll_ww", coll_w[0], 1);
`endif
    b_en = 0; b_wr = 0;
    set_a(1, 0, 0, 4'd7, 0);
    tick;
    check("dual_wr", a_dout_w[0], 32'h2222_1111);
`ifdef BRAM_DP_COLLISION_EN
    check("coll_clr", coll_w[0], 0);
`endif

    // Cross-port read during write.
    set_a(1, 1, 4'hf, 4'd5, 32'h5);
    tick;
    set_a(1, 1, 4'hf, 4'd5, 32'h9);
    b_en = 1; b_wr = 0; b_addr = 4'd5;
    tick;
    check("xrd_old", b_dout_w[0], 32'h5);
    check("xrd_old_v", b_valid_w[0], 1);
`ifdef BRAM_DP_COLLISION_EN
    check("coll_rw", coll_w[0], 1);
`endif
    set_a(0, 0, 0, 0, 0);
    tick;
    check("xrd_new", b_dout_w[0], 32'h9);
    set_a(1, 0, 0, 4'd5, 0);
    tick;
    tick;
`ifdef BRAM_DP_COLLISION_EN
    check("coll_rr", coll_w[0], 0);
`endif
    b_en = 0;

    // Pipelined reads on the OUT_REG instance.
    set_a(1, 1, 4'hf, 4'd1, 32'h101); tick;
    set_a(1, 1, 4'hf, 4'd2, 32'h202); tick;
    set_a(1, 1, 4'hf, 4'd14, 32'hEEEE); tick;
    set_a(0, 0, 0, 0, 0); tick; tick;
    set_a(1, 0, 0, 4'd1, 0); tick;
    check("pl_lat_v", a_valid_w[3], 0);
    set_a(1, 0, 0, 4'd2, 0); tick;
    check("pl_d1", a_dout_w[3], 32'h101);
    check("pl_v1", a_valid_w[3], 1);
    set_a(1, 0, 0, 4'd3, 0); tick;
    check("pl_d2", a_dout_w[3], 32'h202);
    check("pl_v2", a_valid_w[3], 1);
    set_a(0, 0, 0, 0, 0); tick;
    check("pl_d3", a_dout_w[3], 32'hAA22_CC44);
    check("pl_v3", a_valid_w[3], 1);
    tick;
    check("pl_hold", a_dout_w[3], 32'hAA22_CC44);
    check("pl_hold_v", a_valid_w[3], 0);

    // Reset in the middle of the clear sequence.
    rst = 1'b1; tick;
    rst = 1'b0;
    repeat (8) tick;
    check("mid_busy", busy_w[0], 1);
    rst = 1'b1; tick;
    rst = 1'b0;
    count_clear("reclr_len");
    for (int i = 0; i < 16; i++) begin
      set_a(1, 0, 0, 4'(i), 0);
      tick;
      check("reclr_rd", a_dout_w[0], 0);
    end
    set_a(0, 0, 0, 0, 0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
